// File: rtl/uart_tx_sched.sv
// Arbitrates NUM_REQ byte requesters onto one UART TX datapath: capture, load, wait for frame, gap.
// Define UART_TX_SCHED_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module uart_tx_sched #(
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   uart_load,
  output logic [7:0]             uart_tx1,
  input  logic                   uart_busy,
  input  logic                   err_clr,
  output logic                   tx_error,
  output logic                   idle
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_t;

  state_t             state, state_n;
  logic [PTR_W-1:0]   rr_ptr;
  logic [TO_W-1:0]    to_cnt, to_cnt_n;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_n;
  logic [NUM_REQ-1:0] ack_n, grant_n;
  logic               load_n, err_n, idle_n;
  logic [7:0]         tx1_n;

  logic               hi_found;
  logic [PTR_W-1:0]   hi_idx, lo_idx, win_idx;
  logic [7:0]         hi_byte, lo_byte, win_byte;
  logic [NUM_REQ-1:0] win_onehot;

`ifdef UART_TX_SCHED_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  logic [PTR_W-1:0] ptr_n;
`endif

  // Winner search: lowest set bit at or above the pointer, else lowest set bit overall (wrap).
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    hi_byte  = '0;
    lo_idx   = '0;
    lo_byte  = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx  = PTR_W'(i);
        lo_byte = req_data[8*i +: 8];
        if (PTR_W'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(i);
          hi_byte  = req_data[8*i +: 8];
        end
      end
    end
    win_idx    = hi_found ? hi_idx : lo_idx;
    win_byte   = hi_found ? hi_byte : lo_byte;
    win_onehot = NUM_REQ'(1) << win_idx;
  end

  always_comb begin
    state_n   = state;
    ack_n     = '0;
    load_n    = 1'b0;
    grant_n   = grant;
    tx1_n     = uart_tx1;
    to_cnt_n  = to_cnt;
    gap_cnt_n = gap_cnt;
    err_n     = err_clr ? 1'b0 : tx_error;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
    ptr_n     = rr_ptr;
`endif
    unique case (state)
      IDLE: begin
        if (|req && !uart_busy) begin
          state_n = LOAD;
          tx1_n   = win_byte;
          grant_n = win_onehot;
          ack_n   = win_onehot;
          load_n  = 1'b1;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
          ptr_n   = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
      end
      LOAD: begin
        state_n  = WAIT_BUSY;
        to_cnt_n = '0;
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_n = WAIT_DONE;
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          // Lost frame: drop it without retry; a simultaneous err_clr loses to the set.
          err_n     = 1'b1;
          grant_n   = '0;
          state_n   = GAP;
          gap_cnt_n = '0;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!uart_busy) begin
          grant_n   = '0;
          state_n   = GAP;
          gap_cnt_n = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    idle_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ack       <= '0;
      grant     <= '0;
      uart_load <= 1'b0;
      uart_tx1  <= 8'h00;
      tx_error  <= 1'b0;
      idle      <= 1'b1;
      to_cnt    <= '0;
      gap_cnt   <= '0;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_ptr    <= '0;
`endif
    end else begin
      state     <= state_n;
      ack       <= ack_n;
      grant     <= grant_n;
      uart_load <= load_n;
      uart_tx1  <= tx1_n;
      tx_error  <= err_n;
      idle      <= idle_n;
      to_cnt    <= to_cnt_n;
      gap_cnt   <= gap_cnt_n;
`ifndef UART_TX_SCHED_FIXED_PRIO_EN
      rr_ptr    <= ptr_n;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: randomized requests against a behavioural arbitration model.
module tb_uart_tx_sched;

  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 2;
  localparam int TIMEOUT    = 64;

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   ack;
  logic [NUM_REQ-1:0]   grant;
  logic                 uart_load;
  logic [7:0]           uart_tx1;
  logic                 uart_busy;
  logic                 err_clr;
  logic                 tx_error;
  logic                 idle;

  int tests_run    = 0;
  int tests_failed = 0;
  int m_ptr        = 0;

  uart_tx_sched #(
    .NUM_REQ(NUM_REQ),
    .GAP_CYCLES(GAP_CYCLES),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_data(req_data),
    .ack(ack),
    .grant(grant),
    .uart_load(uart_load),
    .uart_tx1(uart_tx1),
    .uart_busy(uart_busy),
    .err_clr(err_clr),
    .tx_error(tx_error),
    .idle(idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference arbitration: scan requesters upward from the pointer, wrapping.
  function automatic int model_winner(input logic [NUM_REQ-1:0] r, input int ptr);
    int start;
`ifdef UART_TX_SCHED_FIXED_PRIO_EN
    start = 0;
`else
    start = ptr;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (r[(start + k) % NUM_REQ]) return (start + k) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    m_ptr = 0;
  endtask

  // Waits (bounded) for a load strobe, then plays the datapath: busy after d cycles for len cycles.
  task automatic do_frame(input int d, input int len, output bit seen, output int waited,
                          output logic [NUM_REQ-1:0] a, output logic [NUM_REQ-1:0] g,
                          output logic [7:0] b);
    seen = 1'b0; waited = 0; a = '0; g = '0; b = '0;
    while (!seen && waited < 300) begin
      @(negedge clk);
      if (uart_load) begin
        seen = 1'b1; a = ack; g = grant; b = uart_tx1;
      end else begin
        waited++;
      end
    end
    if (seen) begin
      repeat (d) @(negedge clk);
      uart_busy = 1'b1;
      repeat (len) @(negedge clk);
      uart_busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    req = '0; uart_busy = 1'b0; err_clr = 1'b0;
    apply_reset();
    tests_run++;
    if ({ack, grant, uart_load, uart_tx1, tx_error, idle} !== {4'b0, 4'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset_values: got ack=%b grant=%b load=%b tx1=%h err=%b idle=%b, want 0/0/0/00/0/1",
               ack, grant, uart_load, uart_tx1, tx_error, idle);
    end
  endtask

  task automatic test_single();
    apply_reset();
    req = 4'b0100;
    req_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    @(negedge clk);
    tests_run++;
    if ({ack, grant, uart_load, uart_tx1, idle} !== {4'b0100, 4'b0100, 1'b1, 8'hA5, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_load: got ack=%b grant=%b load=%b tx1=%h idle=%b, want 0100/0100/1/a5/0",
               ack, grant, uart_load, uart_tx1, idle);
    end
    req = '0;
    @(negedge clk);
    tests_run++;
    if ({ack, uart_load, grant} !== {4'b0, 1'b0, 4'b0100}) begin
      tests_failed++;
      $display("[TB] FAIL single_pulse: got ack=%b load=%b grant=%b, want 0000/0/0100", ack, uart_load, grant);
    end
    uart_busy = 1'b1;
    repeat (10) @(negedge clk);
    tests_run++;
    if (grant !== 4'b0100) begin
      tests_failed++;
      $display("[TB] FAIL single_grant_held: got %b want 0100", grant);
    end
    uart_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({grant, idle} !== {4'b0000, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL single_grant_drop: got grant=%b idle=%b want 0000/0", grant, idle);
    end
    @(negedge clk);
    tests_run++;
    if (idle !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_gap: got idle=%b want 0", idle);
    end
    @(negedge clk);
    tests_run++;
    if ({idle, uart_tx1} !== {1'b1, 8'hA5}) begin
      tests_failed++;
      $display("[TB] FAIL single_idle: got idle=%b tx1=%h want 1/a5", idle, uart_tx1);
    end
  endtask

  task automatic test_round_robin();
    bit seen; int waited; int w;
    logic [NUM_REQ-1:0] a, g; logic [7:0] b;
    apply_reset();
    req = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    for (int f = 0; f < 5; f++) begin
      w = model_winner(req, m_ptr);
      do_frame($urandom_range(1, 3), $urandom_range(1, 8), seen, waited, a, g, b);
      tests_run++;
      if (!seen || g !== NUM_REQ'(1 << w) || a !== NUM_REQ'(1 << w) || b !== req_data[8*w +: 8]) begin
        tests_failed++;
        $display("[TB] FAIL rr_frame%0d: got seen=%0d grant=%b ack=%b tx1=%h want grant=%b tx1=%h",
                 f, seen, g, a, b, NUM_REQ'(1 << w), req_data[8*w +: 8]);
      end
      if (f > 0) begin
        tests_run++;
        if (waited != GAP_CYCLES + 1) begin
          tests_failed++;
          $display("[TB] FAIL rr_spacing%0d: got %0d idle cycles want %0d", f, waited, GAP_CYCLES + 1);
        end
      end
      m_ptr = (w + 1) % NUM_REQ;
    end
    req = '0;
  endtask

  task automatic test_random();
    bit seen; int waited; int w;
    logic [NUM_REQ-1:0] a, g; logic [7:0] b;
    apply_reset();
    req = NUM_REQ'($urandom_range(1, 15));
    req_data = $urandom;
    for (int f = 0; f < 12; f++) begin
      w = model_winner(req, m_ptr);
      do_frame($urandom_range(1, 4), $urandom_range(1, 6), seen, waited, a, g, b);
      tests_run++;
      if (!seen || g !== NUM_REQ'(1 << w) || a !== NUM_REQ'(1 << w) || b !== req_data[8*w +: 8]) begin
        tests_failed++;
        $display("[TB] FAIL rand_frame%0d: req=%b got grant=%b ack=%b tx1=%h want grant=%b tx1=%h",
                 f, req, g, a, b, NUM_REQ'(1 << w), req_data[8*w +: 8]);
      end
      m_ptr = (w + 1) % NUM_REQ;
      req = NUM_REQ'($urandom_range(1, 15));
      req_data = $urandom;
    end
    req = '0;
  endtask

  task automatic test_timeout();
    bit seen;
    apply_reset();
    req = 4'b0001;
    req_data = 32'h0000_005A;
    for (int pass = 0; pass < 2; pass++) begin
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
        @(negedge clk);
        seen = uart_load;
      end
      req = '0;
      tests_run++;
      if (!seen) begin
        tests_failed++;
        $display("[TB] FAIL timeout_load%0d: got no load within 50 cycles want load", pass);
      end
      repeat (TIMEOUT) @(negedge clk);
      tests_run++;
      if ({tx_error, grant} !== {1'b0, 4'b0001}) begin
        tests_failed++;
        $display("[TB] FAIL timeout_pre%0d: got err=%b grant=%b want 0/0001", pass, tx_error, grant);
      end
      if (pass == 1) err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      tests_run++;
      if ({tx_error, grant, idle} !== {1'b1, 4'b0000, 1'b0}) begin
        tests_failed++;
        $display("[TB] FAIL timeout_hit%0d: got err=%b grant=%b idle=%b want 1/0000/0", pass, tx_error, grant, idle);
      end
      repeat (GAP_CYCLES) @(negedge clk);
      tests_run++;
      if (idle !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL timeout_idle%0d: got idle=%b want 1", pass, idle);
      end
      if (pass == 0) begin
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        tests_run++;
        if (tx_error !== 1'b0) begin
          tests_failed++;
          $display("[TB] FAIL err_clr: got err=%b want 0", tx_error);
        end
        req = 4'b0001;
      end
    end
  endtask

  task automatic test_busy_datapath();
    int early;
    uart_busy = 1'b1;
    req = 4'b0001;
    apply_reset();
    early = 0;
    repeat (6) begin
      @(negedge clk);
      if (uart_load || ack != 0) early++;
    end
    tests_run++;
    if (early != 0) begin
      tests_failed++;
      $display("[TB] FAIL busy_hold: got %0d load cycles while busy want 0", early);
    end
    uart_busy = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({uart_load, ack} !== {1'b1, 4'b0001}) begin
      tests_failed++;
      $display("[TB] FAIL busy_release: got load=%b ack=%b want 1/0001", uart_load, ack);
    end
    req = '0;
  endtask

  task automatic test_reset_mid_frame();
    bit seen; int loads;
    apply_reset();
    req = 4'b0010;
    req_data = $urandom;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = uart_load;
    end
    req = '0;
    @(negedge clk);
    uart_busy = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (grant !== 4'b0010) begin
      tests_failed++;
      $display("[TB] FAIL mid_grant: got %b want 0010", grant);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    uart_busy = 1'b0;
    m_ptr = 0;
    tests_run++;
    if ({ack, grant, uart_load, uart_tx1, tx_error, idle} !== {4'b0, 4'b0, 1'b0, 8'h00, 1'b0, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset: got ack=%b grant=%b load=%b tx1=%h err=%b idle=%b want 0/0/0/00/0/1",
               ack, grant, uart_load, uart_tx1, tx_error, idle);
    end
    loads = 0;
    repeat (4) begin
      @(negedge clk);
      if (uart_load) loads++;
    end
    tests_run++;
    if (loads != 0) begin
      tests_failed++;
      $display("[TB] FAIL mid_no_reload: got %0d loads want 0", loads);
    end
    req = 4'b1111;
    @(negedge clk);
    tests_run++;
    if ({uart_load, grant} !== {1'b1, NUM_REQ'(1 << model_winner(req, m_ptr))}) begin
      tests_failed++;
      $display("[TB] FAIL mid_regrant: got load=%b grant=%b want 1/0001", uart_load, grant);
    end
    req = '0;
  endtask

  task automatic test_req_1010();
    bit seen; int waited; int w;
    logic [NUM_REQ-1:0] a, g; logic [7:0] b;
    apply_reset();
    req = 4'b1010;
    req_data = $urandom;
    for (int f = 0; f < 4; f++) begin
      w = model_winner(req, m_ptr);
      do_frame(1, $urandom_range(1, 4), seen, waited, a, g, b);
      tests_run++;
      if (!seen || g !== NUM_REQ'(1 << w) || a !== NUM_REQ'(1 << w)) begin
        tests_failed++;
        $display("[TB] FAIL prio_frame%0d: got grant=%b ack=%b want %b", f, g, a, NUM_REQ'(1 << w));
      end
      m_ptr = (w + 1) % NUM_REQ;
    end
    req = '0;
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; uart_busy = 1'b0; err_clr = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_timeout();
    test_busy_datapath();
    test_reset_mid_frame();
    test_req_1010();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
